// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch controller:
//   fetch_state_e : fetch FSM states
//   NOP_INSTR     : instruction word the IF/ID register holds after reset
//   PC_STEP       : sequential PC increment
//   align_pc()    : forces a target address onto a word boundary
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // issuing a request, waiting for grant
        ST_WAIT = 2'd1,   // granted, waiting for read data
        ST_HOLD = 2'd2,   // data parked in the skid buffer behind a stall
        ST_DROP = 2'd3    // outstanding response belongs to a squashed fetch
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
// Instruction-memory request/response bus.
//   imem_req_o    : request valid (fetch side -> memory)
//   imem_addr_o   : request address (fetch side -> memory)
//   imem_gnt_i    : request accepted this cycle (memory -> fetch side)
//   imem_rvalid_i : read data valid, one per granted request (memory -> fetch side)
//   imem_rdata_i  : instruction word (memory -> fetch side)
// master = fetch controller, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid
// 32-bit holding register for an instruction that arrived while decode was
// stalled. Clear has priority over load.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_data and mark valid
//   i_clear        : discard contents
//   i_data         : instruction word to capture
//   o_data/o_valid : held word and its valid flag
// ---------------------------------------------------------------------------
module fetch_skid (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_valid
);
    logic [31:0] r_data;
    logic        r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch controller: issues one memory request at a time for the
// current PC, loads the IF/ID register, absorbs a response that lands during
// a stall in a skid buffer, and squashes in-flight fetches on redirect.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   pc_i / nxt_pc_o     : current PC in, next PC out (combinational)
//   imem                : instruction-memory bus (master side)
//   stall_i             : hold IF/ID
//   redirect_i/_pc_i    : taken branch/jump from EX and its target
//   if_id_*_o           : IF/ID pipeline register
//   misalign_o          : redirect target not word aligned (combinational)
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    output logic [31:0] nxt_pc_o,
    fetch_if.master     imem,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        misalign_o
);
    fetch_state_e r_state;
    logic         r_imem_req;
    logic         r_if_id_valid;
    logic [31:0]  r_if_id_pc;
    logic [31:0]  r_if_id_instr;

    logic         w_rvalid;
    logic [31:0]  w_rdata;
    logic         w_accept_rsp;
    logic         w_park_rsp;
    logic         w_unpark;
    logic         w_advance;
    logic         w_skid_load;
    logic         w_skid_clear;
    logic [31:0]  w_skid_data;
    logic         w_skid_valid;

    assign w_rvalid = imem.imem_rvalid_i;
    assign w_rdata  = imem.imem_rdata_i;

    // A response goes straight to IF/ID unless decode is stalled on a valid
    // instruction, in which case it is parked in the skid buffer.
    assign w_accept_rsp = (r_state == ST_WAIT) && w_rvalid && (!stall_i || !r_if_id_valid);
    assign w_park_rsp   = (r_state == ST_WAIT) && w_rvalid && stall_i && r_if_id_valid;
    assign w_unpark     = (r_state == ST_HOLD) && !stall_i && w_skid_valid;
    assign w_advance    = !redirect_i && (w_accept_rsp || w_unpark);

    assign w_skid_load  = !redirect_i && w_park_rsp;
    assign w_skid_clear = redirect_i || w_unpark;

    fetch_skid u_skid (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_rdata),
        .o_data  (w_skid_data),
        .o_valid (w_skid_valid)
    );

    // The PC only moves when an instruction is handed to decode, or on redirect.
    always_comb begin
        nxt_pc_o = pc_i;
        if (!rst_ni)
            nxt_pc_o = '0;
        else if (redirect_i)
            nxt_pc_o = align_pc(redirect_pc_i);
        else if (w_advance)
            nxt_pc_o = pc_i + PC_STEP;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_REQ;
            r_imem_req    <= 1'b1;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_INSTR;
        end else if (redirect_i) begin
            r_if_id_valid <= 1'b0;
            // A fetch still in flight must have its response swallowed.
            case (r_state)
                ST_REQ: begin
                    r_state    <= imem.imem_gnt_i ? ST_DROP : ST_REQ;
                    r_imem_req <= !imem.imem_gnt_i;
                end
                ST_WAIT, ST_DROP: begin
                    r_state    <= w_rvalid ? ST_REQ : ST_DROP;
                    r_imem_req <= w_rvalid;
                end
                ST_HOLD: begin
                    r_state    <= ST_REQ;
                    r_imem_req <= 1'b1;
                end
            endcase
        end else begin
            if (w_accept_rsp) begin
                r_if_id_valid <= 1'b1;
                r_if_id_pc    <= pc_i;
                r_if_id_instr <= w_rdata;
            end else if (w_unpark) begin
                r_if_id_valid <= 1'b1;
                r_if_id_pc    <= pc_i;
                r_if_id_instr <= w_skid_data;
            end else if (!stall_i) begin
                r_if_id_valid <= 1'b0;    // bubble
            end

            case (r_state)
                ST_REQ: begin
                    if (imem.imem_gnt_i) begin
                        r_state    <= ST_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_accept_rsp) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                    end else if (w_park_rsp) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (w_rvalid) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign imem.imem_req_o  = r_imem_req;
    assign imem.imem_addr_o = pc_i;
    assign if_id_valid_o    = r_if_id_valid;
    assign if_id_pc_o       = r_if_id_pc;
    assign if_id_instr_o    = r_if_id_instr;
    assign misalign_o       = redirect_i & (|redirect_pc_i[1:0]);
endmodule
